// File: rtl/pipe_exe_stage_if.sv
// ID/EX -> EX -> EX/MEM bundle for the execute stage, plus the MEM/WB
// forwarding value and the stall request back to the front of the pipe.
interface pipe_exe_stage_if;
    logic [31:0] ea, eb, eimm, epc4;
    logic [4:0]  ern;
    logic [4:0]  ealuc;
    logic        ewreg, em2reg, ewmem, ealuimm, eshift, ejal;
    logic [1:0]  a_depen, b_depen;
    logic [31:0] wdi;
    logic        mwreg, mm2reg, mwmem;
    logic [31:0] malu, mb;
    logic [4:0]  mrn;
    logic        exe_stall;

    modport master (
        output ea, eb, eimm, epc4, ern, ealuc,
        output ewreg, em2reg, ewmem, ealuimm, eshift, ejal,
        output a_depen, b_depen, wdi,
        input  mwreg, mm2reg, mwmem, malu, mb, mrn, exe_stall
    );

    modport slave (
        input  ea, eb, eimm, epc4, ern, ealuc,
        input  ewreg, em2reg, ewmem, ealuimm, eshift, ejal,
        input  a_depen, b_depen, wdi,
        output mwreg, mm2reg, mwmem, malu, mb, mrn, exe_stall
    );
endinterface

// File: rtl/pipe_exe_stage.sv
// Execute stage: forwarding, ALU, optional iterative multiplier and EX/MEM register.
// Define EXE_MUL_EN to build the 32-step shift-add multiplier; otherwise mul yields 0.
module pipe_exe_stage #(
    parameter int MUL_CYCLES = 32
) (
    input  logic             clk,
    input  logic             clrn,
    pipe_exe_stage_if.slave  bus
);
    localparam logic [4:0] OP_ADD = 5'b00000, OP_SUB = 5'b00001, OP_AND = 5'b00010,
                           OP_OR  = 5'b00011, OP_XOR = 5'b00100, OP_LUI = 5'b00101,
                           OP_SLL = 5'b00110, OP_SRL = 5'b00111, OP_SRA = 5'b01000,
                           OP_SLT = 5'b01001, OP_MUL = 5'b01010;

    logic [31:0] fwd_a, fwd_b, alua, alub, alu_res, mul_res, result;
    logic        is_mul, stall;

    always_comb begin
        unique case (bus.a_depen)
            2'b01:   fwd_a = bus.malu;
            2'b10:   fwd_a = bus.wdi;
            default: fwd_a = bus.ea;
        endcase
        unique case (bus.b_depen)
            2'b01:   fwd_b = bus.malu;
            2'b10:   fwd_b = bus.wdi;
            default: fwd_b = bus.eb;
        endcase
    end

    assign alua   = bus.eshift  ? {27'b0, bus.eimm[10:6]} : fwd_a;
    assign alub   = bus.ealuimm ? bus.eimm : fwd_b;
    assign is_mul = (bus.ealuc == OP_MUL);

    always_comb begin
        alu_res = '0;
        case (bus.ealuc)
            OP_ADD: alu_res = alua + alub;
            OP_SUB: alu_res = alua - alub;
            OP_AND: alu_res = alua & alub;
            OP_OR:  alu_res = alua | alub;
            OP_XOR: alu_res = alua ^ alub;
            OP_LUI: alu_res = {alub[15:0], 16'b0};
            OP_SLL: alu_res = alub << alua[4:0];
            OP_SRL: alu_res = alub >> alua[4:0];
            OP_SRA: alu_res = $unsigned($signed(alub) >>> alua[4:0]);
            OP_SLT: alu_res = {31'b0, $signed(alua) < $signed(alub)};
            OP_MUL: alu_res = mul_res;
            default: alu_res = '0;
        endcase
    end

    assign result = bus.ejal ? bus.epc4 : alu_res;

`ifdef EXE_MUL_EN
    localparam int CW = $clog2(MUL_CYCLES);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [31:0]     mul_a, mul_b, prod;

    // Operands are captured once on IDLE->BUSY so forwarding changes during BUSY are ignored.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= IDLE;
            cnt   <= '0;
            mul_a <= '0;
            mul_b <= '0;
            prod  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (is_mul) begin
                    mul_a <= fwd_a;
                    mul_b <= fwd_b;
                    prod  <= '0;
                    cnt   <= '0;
                end
                BUSY: begin
                    if (mul_b[0]) prod <= prod + mul_a;
                    mul_a <= mul_a << 1;
                    mul_b <= mul_b >> 1;
                    cnt   <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (is_mul) state_nxt = BUSY;
            BUSY:    if (cnt == CW'(MUL_CYCLES - 1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign stall   = is_mul && (state != DONE);
    assign mul_res = prod;
`else
    assign stall   = 1'b0;
    assign mul_res = '0;
`endif

    assign bus.exe_stall = stall;

    // A stall inserts a bubble: control bits clear, data fields hold.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            bus.mwreg  <= 1'b0;
            bus.mm2reg <= 1'b0;
            bus.mwmem  <= 1'b0;
            bus.malu   <= '0;
            bus.mb     <= '0;
            bus.mrn    <= '0;
        end else if (stall) begin
            bus.mwreg  <= 1'b0;
            bus.mm2reg <= 1'b0;
            bus.mwmem  <= 1'b0;
        end else begin
            bus.mwreg  <= bus.ewreg;
            bus.mm2reg <= bus.em2reg;
            bus.mwmem  <= bus.ewmem;
            bus.malu   <= result;
            bus.mb     <= fwd_b;
            bus.mrn    <= bus.ern;
        end
    end
endmodule

// File: doc/pipe_exe_stage.md
# pipe_exe_stage

Execute stage of the five-stage pipelined CPU, directly downstream of the ID/EX pipeline register. It takes the decoded operands and control from ID/EX and selects forwarded operands with the 2-bit dependency codes. It computes the ALU result, including an iterative 32-cycle multiplier that stalls the front of the pipe, and registers the result into a built-in EX/MEM pipeline register for the memory stage.

## Interface
Parameters:
- `MUL_CYCLES`, 32: shift-add iterations per multiply; fixed, not to be overridden.

Ports:
- `clk` in 1: rising-edge clock.
- `clrn` in 1: reset; asynchronous, active-low.
- `ea`, `eb`, `eimm`, `epc4` in 32 each: operands, immediate and PC+4 from ID/EX.
- `ern` in 5: destination register number.
- `ealuc` in 5: ALU operation code.
- `ewreg`, `em2reg`, `ewmem`, `ealuimm`, `eshift`, `ejal` in 1 each: control bits from ID/EX.
- `a_depen`, `b_depen` in 2 each: forwarding select for A and B.
- `wdi` in 32: write-back data from the MEM/WB stage.
- `mwreg`, `mm2reg`, `mwmem` out 1 each: registered control bits.
- `malu` out 32: registered result.
- `mb` out 32: registered forwarded B, used as store data.
- `mrn` out 5: registered destination.
- `exe_stall` out 1: hold request; PC, IF/ID and ID/EX must hold while it is 1.

## Operation
- Forwarding, applied separately to A and B:
  - depen 00: use `ea` / `eb`.
  - depen 01: use the current `malu` (EX/MEM).
  - depen 10: use `wdi` (MEM/WB).
  - depen 11: reserved; behaves as 00.
- Operand selection:
  - alua = `eshift` ? {27'b0, `eimm[10:6]`} : fwdA.
  - alub = `ealuimm` ? `eimm` : fwdB.
- `ealuc` codes:
  - 00000 add, 00001 sub, 00010 and, 00011 or, 00100 xor.
  - 00101 lui: {alub[15:0], 16'b0}.
  - 00110 sll, 00111 srl, 01000 sra: alub shifted by alua[4:0].
  - 01001 slt: signed compare, result 1 or 0.
  - 01010 mul: low 32 bits of the unsigned product.
  - Any other code: result 0.
- All arithmetic wraps modulo 2^32. No overflow flag.
- Result = `ejal` ? `epc4` : ALU result.
- Multiplier FSM states IDLE, BUSY, DONE:
  - IDLE to BUSY when `ealuc`==mul. fwdA and fwdB are latched on this edge, counter cleared.
  - BUSY: one shift-add step per cycle. BUSY to DONE after `MUL_CYCLES` steps.
  - DONE to IDLE unconditionally. The product is valid in DONE.
- `exe_stall` = (`ealuc`==mul) && state != DONE. It is combinational.
- While `exe_stall`=1, EX/MEM loads a bubble: `mwreg`=`mwmem`=`mm2reg`=0. `malu`, `mb` and `mrn` hold their values.
- A mul arriving in the cycle right after DONE starts a new multiply normally.

## Timing
- Non-mul operations: result appears on the `m*` outputs one cycle after the operation is in EX. No stall.
- Mul, with cycle 0 being the first cycle it is in EX:
  - `exe_stall`=1 for cycles 0..32.
  - Cycle 33 is DONE: `exe_stall`=0, and the product is registered into EX/MEM at the end of cycle 33.
  - Total 33 stall cycles.
- Forwarding sources are sampled only at IDLE to BUSY. Changes on `wdi` or `malu` during BUSY are ignored.
- Reset values: every `m*` output is 0. FSM is IDLE, counter 0, latched operands 0.
- `exe_stall` is 0 out of reset, because ID/EX resets `ealuc` to 0.
- Reset mid-multiply: clrn low aborts the multiply immediately. On release the FSM is IDLE. An instruction still presenting mul restarts with the full 33-cycle stall.

## Configuration
- `EXE_MUL_EN` defined: multiplier FSM present; behaviour as above.
- `EXE_MUL_EN` undefined:
  - No FSM and no counter.
  - `exe_stall` tied to 0.
  - mul code yields result 0 with the normal one-cycle latency.

## Test plan
- Add: `ea`=5, `eb`=7, depen 00/00, `ealuc`=00000, `ewreg`=1, `ern`=3 -> next edge `malu`=12, `mrn`=3, `mwreg`=1.
- Forwarding, A side: following sub with `a_depen`=01, `eb`=1 -> `malu`=11.
- Forwarding, B side: or with `b_depen`=10, `wdi`=0x100, `ea`=0x0F -> `malu`=0x10F, `mb`=0x100.
- Shift: `eshift`=1, `eimm[10:6]`=4, `eb`=0x80000000, sra -> `malu`=0xF8000000. Then `ejal`=1, `epc4`=0x104 -> `malu`=0x104.
- Multiply (with `EXE_MUL_EN`): `ea`=0x00010003, `eb`=0x00020005, mul -> `exe_stall`=1 for exactly 33 cycles with `mwreg`=0 throughout; then `malu`=0x000B000F and `mwreg` follows `ewreg`. A back-to-back mul restarts the stall.
- Reset mid-multiply: clrn low at cycle 10 of a multiply -> all `m*` outputs 0 and FSM IDLE. Release with mul held -> full 33-cycle stall and correct product. Same multiply with `EXE_MUL_EN` undefined -> no stall, `malu`=0.
